data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Shares the single-port 64-bit data memory between two requesters: m0 (CPU load/store unit)
//  and m1 (host loader / packet DMA). Round-robin arbitration over byte-addressed, size-tagged
//  requests. Sub-word stores become read-modify-write on the full-word memory. Sub-word loads
//  are lane-extracted and zero-extended. Sits between the core/host and the data memory.
// PARAMETERS
//  data_size     64  memory word width (fixed 64; eBPF DW)
//  address_size  11  memory word-address width; requester byte address = address_size+3 bits
// PORTS
//  clk        in   1      clock, all state on posedge
//  rst        in   1      asynchronous, active-high reset
//  mN_stb     in   1      request (N=0,1); held high until mN_ack
//  mN_adr     in   AS+3   byte address; bits[2:0] = byte offset within 64-bit word
//  mN_we      in   1      1=store, 0=load
//  mN_ww      in   4      size one-hot: 0001=B, 0010=H, 0100=W, 1000=DW
//  mN_dat_w   in   64     store data, right-justified (LSBs)
//  mN_dat_r   out  64     load data, zero-extended; valid only while mN_ack=1
//  mN_ack     out  1      one-cycle completion pulse
//  mN_err     out  1      with mN_ack: request was misaligned or bad ww; no memory access
//  mem_stb    out  1      memory request
//  mem_adr    out  AS     memory word address
//  mem_we     out  1      memory write enable (full-word write)
//  mem_ww     out  4      constant 4'b1000
//  mem_dat_w  out  64     full word to write
//  mem_dat_r  in   64     combinational read data of mem[mem_adr]
// BEHAVIOUR
//  Reset: FSM=IDLE; last_grant=m1 (m0 wins first contest); all acks/errs/mem_stb/mem_we=0;
//   mN_dat_r=0; latched request regs=0.
//  FSM states: IDLE, RD, WR, ACK.
//  IDLE: if any stb, grant one: only one high -> it; both high -> the one != last_grant.
//   Latch adr/we/ww/dat_w, set last_grant. Checks: ww not one-hot, or offset not multiple of
//   size (H:adr[0]=0, W:adr[1:0]=0, DW:adr[2:0]=0) -> go ACK with err=1, no mem access.
//   Else: load or sub-word store -> RD; DW store -> WR.
//  RD: mem_stb=1, mem_adr=latched adr[AS+2:3]. Load: rdata = (mem_dat_r >> 8*off) masked to
//   size, zero-extended -> ACK. Sub-word store: merge new lanes into mem_dat_r -> WR.
//  WR: mem_stb=1, mem_we=1, mem_dat_w=merged word (DW: dat_w as-is) -> ACK.
//  ACK: granted mN_ack=1 for exactly one cycle (mN_err as decided), mN_dat_r=rdata (0 for
//   stores/err) -> IDLE. Non-granted master's ack/err stay 0.
//  Latency stb->ack (stb sampled in IDLE): load 3 cycles, DW store 3, sub-word store 4,
//   error 2. Back-to-back: next grant evaluated in the cycle after ACK.
//  Little-endian lanes: byte k = bits[8k+7:8k]. Merge writes only lanes off..off+size-1;
//   other lanes retain old value bit-exact.
//  Requester must drop stb the cycle after ack or it is taken as a new request. Dropping stb
//   mid-transaction does not abort; the access completes and ack still pulses.
//  Latched data is used after grant; changes on mN_* inputs after grant are ignored.
//  Outside RD/WR: mem_stb=0, mem_we=0. mem_we never high in RD, IDLE, or ACK.
//  rst mid-transaction: immediate return to IDLE, pending write dropped (no mem_we after
//   rst rises), no ack issued.
// TESTING
//  1 DW store m0 adr=0x10 data=0x1122334455667788, then DW load -> ack at +3, dat_r equal.
//  2 B store 0xAB to adr=0x13 over word 0x1122334455667788 -> mem word 0x11223344AB667788;
//    H load adr=0x12 -> dat_r=0x0000_0000_0000_AB66.
//  3 m0,m1 stb same cycle after reset -> m0 first; both held -> m1 next, alternating.
//  4 W load adr=0x06 (misaligned) -> ack+err at +2, no mem_stb, dat_r=0; ww=0011 -> same.
//  5 rst pulsed during WR of sub-word store -> no mem_we, no ack, mem unchanged, FSM IDLE.
//  6 m1 drops stb mid-RD -> access completes, single m1_ack pulse, m0 unaffected.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - round-robin two-master arbiter for the 64-bit data memory with sub-word RMW
module data_mem_arbiter #(
    parameter int data_size    = 64,
    parameter int address_size = 11
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      m0_stb,
    input  logic [address_size+2:0]   m0_adr,
    input  logic                      m0_we,
    input  logic [3:0]                m0_ww,
    input  logic [data_size-1:0]      m0_dat_w,
    output logic [data_size-1:0]      m0_dat_r,
    output logic                      m0_ack,
    output logic                      m0_err,
    input  logic                      m1_stb,
    input  logic [address_size+2:0]   m1_adr,
    input  logic                      m1_we,
    input  logic [3:0]                m1_ww,
    input  logic [data_size-1:0]      m1_dat_w,
    output logic [data_size-1:0]      m1_dat_r,
    output logic                      m1_ack,
    output logic                      m1_err,
    output logic                      mem_stb,
    output logic [address_size-1:0]   mem_adr,
    output logic                      mem_we,
    output logic [3:0]                mem_ww,
    output logic [data_size-1:0]      mem_dat_w,
    input  logic [data_size-1:0]      mem_dat_r
);
    localparam int AW = address_size + 3;

    typedef enum logic [1:0] {IDLE, RD, WR, ACK} state_t;
    state_t state, state_n;

    logic                 last_grant, gnt;
    logic [AW-1:0]        l_adr;
    logic                 l_we;
    logic [3:0]           l_ww;
    logic [data_size-1:0] wdata;

    // Grant selection: lone requester wins, contest goes to the one not served last.
    logic                 req_any, pick, sel_we, sel_bad;
    logic [AW-1:0]        sel_adr;
    logic [3:0]           sel_ww;
    logic [data_size-1:0] sel_dat;

    assign req_any = m0_stb | m1_stb;
    assign pick    = (m0_stb && m1_stb) ? ~last_grant : m1_stb;
    assign sel_adr = pick ? m1_adr   : m0_adr;
    assign sel_we  = pick ? m1_we    : m0_we;
    assign sel_ww  = pick ? m1_ww    : m0_ww;
    assign sel_dat = pick ? m1_dat_w : m0_dat_w;

    always_comb begin
        sel_bad = 1'b0;
        case (sel_ww)
            4'b0001: sel_bad = 1'b0;
            4'b0010: sel_bad = sel_adr[0];
            4'b0100: sel_bad = |sel_adr[1:0];
            4'b1000: sel_bad = |sel_adr[2:0];
            default: sel_bad = 1'b1;
        endcase
    end

    // Byte-lane masks for the latched request.
    logic [7:0]           size_bm, lane_bm;
    logic [5:0]           shamt;
    logic [data_size-1:0] size_mask, lane_mask, merged, load_data;

    always_comb begin
        case (l_ww)
            4'b0001: size_bm = 8'h01;
            4'b0010: size_bm = 8'h03;
            4'b0100: size_bm = 8'h0f;
            default: size_bm = 8'hff;
        endcase
        lane_bm   = size_bm << l_adr[2:0];
        size_mask = '0;
        lane_mask = '0;
        for (int i = 0; i < 8; i++) begin
            size_mask[8*i +: 8] = {8{size_bm[i]}};
            lane_mask[8*i +: 8] = {8{lane_bm[i]}};
        end
    end

    assign shamt     = {l_adr[2:0], 3'b000};
    assign merged    = (mem_dat_r & ~lane_mask) | ((wdata << shamt) & lane_mask);
    assign load_data = (mem_dat_r >> shamt) & size_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        mem_stb   = 1'b0;
        mem_we    = 1'b0;
        mem_dat_w = '0;
        case (state)
            IDLE: begin
                if (req_any) begin
                    if (sel_bad)                          state_n = ACK;
                    else if (sel_we && sel_ww == 4'b1000) state_n = WR;
                    else                                  state_n = RD;
                end
            end
            RD: begin
                mem_stb = 1'b1;
                state_n = l_we ? WR : ACK;
            end
            WR: begin
                mem_stb   = 1'b1;
                mem_we    = 1'b1;
                mem_dat_w = wdata;
                state_n   = ACK;
            end
            default: state_n = IDLE;
        endcase
    end

    assign mem_adr = l_adr[AW-1:3];
    assign mem_ww  = 4'b1000;

    // Completion is registered so ack/err/dat_r are high for exactly the ACK cycle.
    logic                 fin, fin_who, fin_err;
    logic [data_size-1:0] fin_dat;

    assign fin     = (state == IDLE && req_any && sel_bad) || (state == RD && !l_we) || (state == WR);
    assign fin_who = (state == IDLE) ? pick : gnt;
    assign fin_err = (state == IDLE);
    assign fin_dat = (state == RD) ? load_data : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            gnt        <= 1'b0;
            l_adr      <= '0;
            l_we       <= 1'b0;
            l_ww       <= '0;
            wdata      <= '0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_err     <= 1'b0;
            m1_err     <= 1'b0;
            m0_dat_r   <= '0;
            m1_dat_r   <= '0;
        end else begin
            m0_ack   <= fin && !fin_who;
            m1_ack   <= fin && fin_who;
            m0_err   <= fin && !fin_who && fin_err;
            m1_err   <= fin && fin_who && fin_err;
            m0_dat_r <= (fin && !fin_who) ? fin_dat : '0;
            m1_dat_r <= (fin && fin_who) ? fin_dat : '0;
            if (state == IDLE && req_any) begin
                gnt        <= pick;
                last_grant <= pick;
                l_adr      <= sel_adr;
                l_we       <= sel_we;
                l_ww       <= sel_ww;
                wdata      <= sel_dat;
            end else if (state == RD && l_we) begin
                wdata      <= merged;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - randomized self-checking bench for data_mem_arbiter against a byte-array model
module tb_data_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_stb = 0, m0_we = 0, m1_stb = 0, m1_we = 0;
    logic [13:0] m0_adr = '0, m1_adr = '0;
    logic [3:0]  m0_ww = '0, m1_ww = '0;
    logic [63:0] m0_dat_w = '0, m1_dat_w = '0;
    logic [63:0] m0_dat_r, m1_dat_r;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic        mem_stb, mem_we;
    logic [10:0] mem_adr;
    logic [3:0]  mem_ww;
    logic [63:0] mem_dat_w, mem_dat_r;

    int n_tests = 0;
    int n_fail  = 0;
    int viol    = 0;

    logic [63:0] mem [0:2047];
    logic [7:0]  ref_bytes [0:16383];

    always #5 clk = ~clk;

    data_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_stb(m0_stb), .m0_adr(m0_adr), .m0_we(m0_we), .m0_ww(m0_ww), .m0_dat_w(m0_dat_w),
        .m0_dat_r(m0_dat_r), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_stb(m1_stb), .m1_adr(m1_adr), .m1_we(m1_we), .m1_ww(m1_ww), .m1_dat_w(m1_dat_w),
        .m1_dat_r(m1_dat_r), .m1_ack(m1_ack), .m1_err(m1_err),
        .mem_stb(mem_stb), .mem_adr(mem_adr), .mem_we(mem_we), .mem_ww(mem_ww),
        .mem_dat_w(mem_dat_w), .mem_dat_r(mem_dat_r)
    );

    assign mem_dat_r = mem[mem_adr];
    always @(posedge clk) if (mem_stb && mem_we) mem[mem_adr] <= mem_dat_w;

    always @(negedge clk)
        if (!rst && ((mem_we && !mem_stb) || (mem_stb && mem_ww != 4'b1000))) viol++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_load(input int adr, input int size);
        logic [63:0] r = '0;
        for (int k = 0; k < size; k++) r[8*k +: 8] = ref_bytes[adr + k];
        return r;
    endfunction

    task automatic set_master(input int m, input logic stb, input logic [13:0] adr, input logic we,
                              input logic [3:0] ww, input logic [63:0] dat);
        if (m == 0) begin
            m0_stb = stb; m0_adr = adr; m0_we = we; m0_ww = ww; m0_dat_w = dat;
        end else begin
            m1_stb = stb; m1_adr = adr; m1_we = we; m1_ww = ww; m1_dat_w = dat;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m0_stb = 0; m1_stb = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Latency counts cycles: the IDLE cycle in which stb is first seen is cycle 1.
    task automatic run_txn(input int m, input logic [13:0] adr, input logic we, input logic [3:0] ww,
                           input logic [63:0] dat, output logic [63:0] rd, output logic er,
                           output int lat, output int stb_cnt, output int other_ack);
        bit done = 0;
        @(posedge clk);
        @(negedge clk);
        set_master(m, 1'b1, adr, we, ww, dat);
        lat = 1; stb_cnt = 0; other_ack = 0; rd = '0; er = 1'b0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (mem_stb) stb_cnt++;
            if ((m == 0) ? m1_ack : m0_ack) other_ack++;
            if ((m == 0) ? m0_ack : m1_ack) begin
                done = 1;
                rd   = (m == 0) ? m0_dat_r : m1_dat_r;
                er   = (m == 0) ? m0_err : m1_err;
            end
        end
        if (m == 0) m0_stb = 1'b0; else m1_stb = 1'b0;
        if (!done) lat = 99;
    endtask

    task automatic txn_ref(input string tag, input int m, input int adr, input logic we,
                           input logic [3:0] ww, input logic [63:0] dat);
        int size, exp_lat, exp_stb, lat, stb_cnt, other_ack;
        logic bad, er;
        logic [63:0] exp_rd, rd;
        case (ww)
            4'b0001: size = 1;
            4'b0010: size = 2;
            4'b0100: size = 4;
            4'b1000: size = 8;
            default: size = 0;
        endcase
        bad = (size == 0) ? 1'b1 : ((adr % size) != 0);
        exp_rd = '0;
        if (bad) begin
            exp_lat = 2; exp_stb = 0;
        end else if (we) begin
            exp_lat = (size == 8) ? 3 : 4;
            exp_stb = (size == 8) ? 1 : 2;
        end else begin
            exp_lat = 3; exp_stb = 1;
            exp_rd  = ref_load(adr, size);
        end
        run_txn(m, adr[13:0], we, ww, dat, rd, er, lat, stb_cnt, other_ack);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_err"}, {63'd0, er}, {63'd0, bad});
        check({tag, "_rd"}, rd, exp_rd);
        check({tag, "_memstb"}, 64'(stb_cnt), 64'(exp_stb));
        check({tag, "_other"}, 64'(other_ack), 64'd0);
        if (!bad && we)
            for (int k = 0; k < size; k++) ref_bytes[adr + k] = dat[8*k +: 8];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int order[4];
        int n_acks, both, acks0, acks1;
        logic [63:0] rd6;
        logic [3:0]  ww_tbl[4];

        for (int w = 0; w < 2048; w++) mem[w] = '0;
        for (int b = 0; b < 16384; b++) ref_bytes[b] = 8'h00;
        for (int w = 0; w < 16; w++) begin
            mem[w] = {$urandom, $urandom};
            for (int k = 0; k < 8; k++) ref_bytes[8*w + k] = mem[w][8*k +: 8];
        end

        do_reset();
        #1;
        check("reset_ctl", {58'd0, m0_ack, m1_ack, m0_err, m1_err, mem_stb, mem_we}, 64'd0);
        check("reset_dat0", m0_dat_r, 64'd0);
        check("reset_dat1", m1_dat_r, 64'd0);

        txn_ref("dw_store", 0, 'h10, 1'b1, 4'b1000, 64'h1122334455667788);
        txn_ref("dw_load", 0, 'h10, 1'b0, 4'b1000, 64'd0);
        txn_ref("b_store", 0, 'h13, 1'b1, 4'b0001, 64'h00000000000000AB);
        check("b_store_word", mem[2], 64'h11223344AB667788);
        txn_ref("h_load", 0, 'h12, 1'b0, 4'b0010, 64'd0);
        txn_ref("w_misalign", 0, 'h06, 1'b0, 4'b0100, 64'd0);
        txn_ref("ww_bad", 1, 'h10, 1'b0, 4'b0011, 64'd0);

        // Both masters contend right after reset and keep stb held.
        do_reset();
        for (int i = 0; i < 4; i++) order[i] = 2;
        n_acks = 0; both = 0;
        set_master(0, 1'b1, 14'h10, 1'b0, 4'b1000, 64'd0);
        set_master(1, 1'b1, 14'h18, 1'b0, 4'b1000, 64'd0);
        for (int c = 0; c < 40 && n_acks < 4; c++) begin
            @(posedge clk);
            #1;
            if (m0_ack && m1_ack) both++;
            if (m0_ack && n_acks < 4) order[n_acks++] = 0;
            if (m1_ack && n_acks < 4) order[n_acks++] = 1;
        end
        m0_stb = 0; m1_stb = 0;
        check("arb_count", 64'(n_acks), 64'd4);
        check("arb_both", 64'(both), 64'd0);
        for (int i = 0; i < 4; i++) check($sformatf("arb_order%0d", i), 64'(order[i]), 64'(i % 2));

        // Reset lands while a byte store is in its write cycle.
        @(posedge clk);
        @(negedge clk);
        set_master(0, 1'b1, 14'h20, 1'b1, 4'b0001, 64'h5A);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_wr_we_before", {63'd0, mem_we}, 64'd1);
        rst = 1'b1;
        m0_stb = 1'b0;
        #1;
        check("rst_wr_we_after", {62'd0, mem_stb, mem_we}, 64'd0);
        acks0 = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (m0_ack || m1_ack) acks0++;
            if (c == 1) rst = 1'b0;
        end
        check("rst_wr_noack", 64'(acks0), 64'd0);
        check("rst_wr_mem", mem[4], ref_load('h20, 8));
        txn_ref("rst_after_load", 0, 'h20, 1'b0, 4'b0001, 64'd0);

        // m1 withdraws stb once the read is under way.
        @(posedge clk);
        @(negedge clk);
        set_master(1, 1'b1, 14'h24, 1'b0, 4'b0100, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        m1_stb = 1'b0;
        acks0 = 0; acks1 = 0; rd6 = '0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (m0_ack) acks0++;
            if (m1_ack) begin acks1++; rd6 = m1_dat_r; end
        end
        check("drop_m1_acks", 64'(acks1), 64'd1);
        check("drop_m0_acks", 64'(acks0), 64'd0);
        check("drop_m1_rd", rd6, ref_load('h24, 4));

        ww_tbl[0] = 4'b0001; ww_tbl[1] = 4'b0010; ww_tbl[2] = 4'b0100; ww_tbl[3] = 4'b1000;
        for (int t = 0; t < 80; t++) begin
            int r, m, adr;
            logic [3:0] ww;
            logic we;
            r   = $urandom_range(0, 9);
            ww  = (r < 8) ? ww_tbl[r % 4] : ((r == 8) ? 4'b0000 : 4'b0110);
            m   = $urandom_range(0, 1);
            we  = $urandom_range(0, 1);
            adr = $urandom_range(0, 127);
            txn_ref($sformatf("rnd%0d", t), m, adr, we, ww, {$urandom, $urandom});
        end

        for (int w = 0; w < 16; w++) check($sformatf("mem_word%0d", w), mem[w], ref_load(8*w, 8));
        check("proto_viol", 64'(viol), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
